// File: rtl/shf_pipe_if.sv
//------------------------------------------------------------------------------
// shf_pipe_if
// Handshake bundle for the shf_pipe shift/rotate unit.
//   in_valid / in_ready        : request handshake (producer -> unit)
//   in_op, in_data, in_cnt     : operation code, operand, raw 8-bit count
//   out_valid / out_ready      : result handshake (unit -> writeback)
//   out_data, out_cf, out_of   : result and x86 carry/overflow flags
//   out_flag_upd               : 1 when the architectural flags must be written
// Modports: master drives requests and accepts results, slave is the unit.
//------------------------------------------------------------------------------
interface shf_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_data;
   logic [7:0]       in_cnt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_cf;
   logic             out_of;
   logic             out_flag_upd;

   modport master (
      output in_valid, in_op, in_data, in_cnt, out_ready,
      input  in_ready, out_valid, out_data, out_cf, out_of, out_flag_upd
   );

   modport slave (
      input  in_valid, in_op, in_data, in_cnt, out_ready,
      output in_ready, out_valid, out_data, out_cf, out_of, out_flag_upd
   );
endinterface

// File: rtl/shf_pipe.sv
//------------------------------------------------------------------------------
// shf_pipe
// Two-stage pipelined shift/rotate unit (SHL/SAL, SHR, SAR, ROL, ROR) with
// x86 CF/OF generation and a flag-update qualifier.
//
// Parameters:
//   WIDTH : operand width (8, 16, 32 or 64)
//   CNT_W : log2(WIDTH); the effective count is in_cnt[CNT_W-1:0]
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : shf_pipe_if slave modport (request and result handshakes)
//
// Stage 1 applies the upper half of the count bits and registers the partial
// result together with the op, count and original operand. Stage 2 applies
// the low count bits, derives the flags and registers every output.
// Latency is two cycles; a full pipe can accept and drain in the same cycle.
//------------------------------------------------------------------------------
module shf_pipe #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input logic        clk,
   input logic        rst_n,
   shf_pipe_if.slave  bus
);

   localparam int LO_W = CNT_W / 2;
   localparam int HI_W = CNT_W - LO_W;

   localparam logic [2:0] OP_SHL = 3'd0;
   localparam logic [2:0] OP_SHR = 3'd1;
   localparam logic [2:0] OP_SAR = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;

   // Applies one op by a partial amount. Because shifts and rotates compose
   // additively, stage 1 and stage 2 each call this with a disjoint subset
   // of the count bits. Rotates use a doubled operand so the wrapped bits
   // fall out of a plain shift.
   function automatic logic [WIDTH-1:0] shift_by(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] val,
      input logic [CNT_W-1:0] amt
   );
      logic [2*WIDTH-1:0] dbl;
      logic [WIDTH-1:0]   res;
      dbl = {val, val};
      res = val;
      case (op)
         OP_SHL: res = val << amt;
         OP_SHR: res = val >> amt;
         OP_SAR: res = $signed(val) >>> amt;
         OP_ROL: begin
            dbl = dbl << amt;
            res = dbl[2*WIDTH-1:WIDTH];
         end
         OP_ROR: begin
            dbl = dbl >> amt;
            res = dbl[WIDTH-1:0];
         end
         default: res = val;
      endcase
      return res;
   endfunction

   // Stage state
   logic             s1_valid;
   logic [2:0]       s1_op;
   logic [CNT_W-1:0] s1_cnt;
   logic [WIDTH-1:0] s1_orig;
   logic [WIDTH-1:0] s1_part;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_data;
   logic             s2_cf;
   logic             s2_of;
   logic             s2_upd;

   // Handshake
   logic s1_adv;
   assign s1_adv       = !s2_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s1_adv;

   // Count bits above CNT_W-1 are architecturally ignored.
   logic [7:0] cnt_unused;
   assign cnt_unused = bus.in_cnt;

   logic [CNT_W-1:0] c_in;
   logic [CNT_W-1:0] amt_hi;
   logic [WIDTH-1:0] part_in;
   assign c_in    = bus.in_cnt[CNT_W-1:0];
   assign amt_hi  = {c_in[CNT_W-1:LO_W], {LO_W{1'b0}}};
   assign part_in = shift_by(bus.in_op, bus.in_data, amt_hi);

   // Stage 1 register: loads on accept, holds while stage 2 is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= 3'd0;
         s1_cnt   <= {CNT_W{1'b0}};
         s1_orig  <= {WIDTH{1'b0}};
         s1_part  <= {WIDTH{1'b0}};
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_op   <= bus.in_op;
            s1_cnt  <= c_in;
            s1_orig <= bus.in_data;
            s1_part <= part_in;
         end
      end
   end

   // Stage 2 combinational: finish the shift with the low count bits.
   logic [CNT_W-1:0] amt_lo;
   logic [WIDTH-1:0] s2_res;
   logic [CNT_W-1:0] idx_shl;
   logic [CNT_W-1:0] idx_shr;
   assign amt_lo  = {{HI_W{1'b0}}, s1_cnt[LO_W-1:0]};
   assign s2_res  = shift_by(s1_op, s1_part, amt_lo);
   // Modulo-WIDTH arithmetic gives m-c and c-1 directly as bit indices.
   assign idx_shl = {CNT_W{1'b0}} - s1_cnt;
   assign idx_shr = s1_cnt - {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] data_n;
   logic             cf_n;
   logic             of_n;
   logic             upd_n;

   // Flag derivation; a zero count or a pass-through op leaves data and flags untouched.
   always_comb begin
      data_n = s1_orig;
      cf_n   = 1'b0;
      of_n   = 1'b0;
      upd_n  = 1'b0;
      if ((s1_op > OP_ROR) || (s1_cnt == {CNT_W{1'b0}})) begin
         data_n = s1_orig;
         cf_n   = 1'b0;
         of_n   = 1'b0;
         upd_n  = 1'b0;
      end else begin
         data_n = s2_res;
         upd_n  = 1'b1;
         case (s1_op)
            OP_SHL:         cf_n = s1_orig[idx_shl];
            OP_SHR, OP_SAR: cf_n = s1_orig[idx_shr];
            OP_ROL:         cf_n = s2_res[0];
            OP_ROR:         cf_n = s2_res[WIDTH-1];
            default:        cf_n = 1'b0;
         endcase
         // OF is only defined for single-bit shifts; report 0 otherwise.
         if (s1_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            case (s1_op)
               OP_SHL, OP_ROL: of_n = s2_res[WIDTH-1] ^ cf_n;
               OP_SHR:         of_n = s1_orig[WIDTH-1];
               OP_ROR:         of_n = s2_res[WIDTH-1] ^ s2_res[WIDTH-2];
               default:        of_n = 1'b0;
            endcase
         end else begin
            of_n = 1'b0;
         end
      end
   end

   // Stage 2 register: output holds stable while out_valid & !out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_data  <= {WIDTH{1'b0}};
         s2_cf    <= 1'b0;
         s2_of    <= 1'b0;
         s2_upd   <= 1'b0;
      end else if (s1_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= data_n;
            s2_cf   <= cf_n;
            s2_of   <= of_n;
            s2_upd  <= upd_n;
         end
      end
   end

   assign bus.out_valid    = s2_valid;
   assign bus.out_data     = s2_data;
   assign bus.out_cf       = s2_cf;
   assign bus.out_of       = s2_of;
   assign bus.out_flag_upd = s2_upd;

endmodule
